// File: rtl/pipelined_borrow_lookahead_subtractor_if.sv
// Valid/ready stream bundle for the pipelined borrow-lookahead subtractor.
// The master drives operands and out_ready. The slave returns the result and its flags.
interface pipelined_borrow_lookahead_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/pipelined_borrow_lookahead_subtractor.sv
// Streaming a - b - bin. Each pipeline stage resolves one 4-bit borrow-lookahead group.
// The borrow is registered between stages, and the whole pipe stalls together on backpressure.
module pipelined_borrow_lookahead_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input logic                                    clk,
  input logic                                    rst_n,
  pipelined_borrow_lookahead_subtractor_if.slave bus
);
  localparam int unsigned GRP    = 4;
  localparam int unsigned STAGES = WIDTH / GRP;
  localparam int unsigned LAST   = STAGES - 1;

  // Two-level lookahead over one nibble; returns {borrow_out, diff_nibble}.
  function automatic logic [GRP:0] grp_sub(
    input logic [GRP-1:0] x,
    input logic [GRP-1:0] y,
    input logic           bi
  );
    logic [GRP-1:0] g;
    logic [GRP-1:0] p;
    logic [GRP-1:0] c;
    logic           bo;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = bi;
    c[1] = g[0] | (p[0] & bi);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & bi);
    bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bi);
    return {bo, x ^ y ^ c};
  endfunction

  logic advance_c;

  // The pipe moves only when the output slot is empty or is being drained.
  assign advance_c    = ~g_stage[LAST].vld_q | bus.out_ready;
  assign bus.in_ready = advance_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be processed, and completed diff bits, after this stage.
    localparam int unsigned UW = WIDTH - GRP * k;
    localparam int unsigned DW = GRP * (k + 1);

    logic [UW-1:0] a_up;
    logic [UW-1:0] b_up;
    logic          v_in;
    logic          bi_in;
    logic [GRP:0]  res;
    logic [DW-1:0] d_nxt;
    logic          vld_q;
    logic          brw_q;
    logic [DW-1:0] d_q;

    if (k == 0) begin : g_head
      assign a_up  = bus.a;
      assign b_up  = bus.b;
      assign v_in  = bus.in_valid;
      assign bi_in = bus.bin;
      assign d_nxt = res[GRP-1:0];
    end else begin : g_body
      assign a_up  = g_stage[k-1].g_carry.a_q;
      assign b_up  = g_stage[k-1].g_carry.b_q;
      assign v_in  = g_stage[k-1].vld_q;
      assign bi_in = g_stage[k-1].brw_q;
      assign d_nxt = {res[GRP-1:0], g_stage[k-1].d_q};
    end

    assign res = grp_sub(a_up[GRP-1:0], b_up[GRP-1:0], bi_in);

    always_ff @(posedge clk or negedge rst_n) begin : p_stage
      if (!rst_n) begin
        vld_q <= 1'b0;
        brw_q <= 1'b0;
        d_q   <= '0;
      end else if (advance_c) begin
        vld_q <= v_in;
        brw_q <= res[GRP];
        d_q   <= d_nxt;
      end
    end

    if (k < LAST) begin : g_carry
      // Unprocessed upper nibbles travel with the beat.
      logic [UW-GRP-1:0] a_q;
      logic [UW-GRP-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin : p_carry
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance_c) begin
          a_q <= a_up[UW-1:GRP];
          b_q <= b_up[UW-1:GRP];
        end
      end
    end else begin : g_tail
      logic ovf_c;
      logic zero_c;
      logic ovf_q;
      logic zero_q;

      assign ovf_c  = (a_up[GRP-1] ^ b_up[GRP-1]) & (res[GRP-1] ^ a_up[GRP-1]);
      assign zero_c = ~|d_nxt;

      always_ff @(posedge clk or negedge rst_n) begin : p_flags
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance_c) begin
          ovf_q  <= ovf_c;
          zero_q <= zero_c;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[LAST].vld_q;
  assign bus.diff      = g_stage[LAST].d_q;
  assign bus.bout      = g_stage[LAST].brw_q;
  assign bus.ovf       = g_stage[LAST].g_tail.ovf_q;
  assign bus.zero      = g_stage[LAST].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_borrow_lookahead_subtractor.sv
// Directed bench for the 16-bit pipelined borrow-lookahead subtractor.
// Covers latency, flags, stall hold, ordering and reset in the middle of operation.
module tb_pipelined_borrow_lookahead_subtractor;
  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipelined_borrow_lookahead_subtractor_if #(.WIDTH(W)) bus ();

  pipelined_borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: {bout, ovf, zero, diff}.
  function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
    logic [W:0] w;
    logic       o;
    w = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    o = (x[W-1] ^ y[W-1]) & (w[W-1] ^ x[W-1]);
    return {w[W], o, (w[W-1:0] == '0), w[W-1:0]};
  endfunction

  // One isolated beat: checks the 4-cycle latency, the result and the drain.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input logic ez, input string tag);
    bus.a         = ta;
    bus.b         = tbv;
    bus.bin       = tbin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".diff"},      32'(bus.diff),      32'(ed));
    chk({tag, ".bout"},      32'(bus.bout),      32'(eb));
    chk({tag, ".ovf"},       32'(bus.ovf),       32'(eo));
    chk({tag, ".zero"},      32'(bus.zero),      32'(ez));
    @(posedge clk); #1;
    chk({tag, ".drained"},   32'(bus.out_valid), 32'd0);
  endtask

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vc [8];
  logic [W+2:0] exp_q [8];

  initial begin
    int sent;
    int recv;
    int cyc;

    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.diff",      32'(bus.diff),      32'd0);
    chk("rst.bout",      32'(bus.bout),      32'd0);
    chk("rst.ovf",       32'(bus.ovf),       32'd0);
    chk("rst.zero",      32'(bus.zero),      32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "t1");
    run_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, "t2");
    run_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, "t3a");
    run_one(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, "t3b");
    run_one(16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, "t4a");
    run_one(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "t4b");
    run_one(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, "chain");
    run_one(16'h5A5A, 16'h1234, 1'b1, 16'h4825, 1'b0, 1'b0, 1'b0, "mix");

    // Back-to-back stream with a 3-cycle output stall.
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0;
    va[1] = 16'h1000; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'h0F0F; vb[2] = 16'hF0F0; vc[2] = 1'b1;
    va[3] = 16'hABCD; vb[3] = 16'hABCD; vc[3] = 1'b0;
    va[4] = 16'h8000; vb[4] = 16'h8000; vc[4] = 1'b1;
    va[5] = 16'h0001; vb[5] = 16'h0002; vc[5] = 1'b0;
    va[6] = 16'h7FFF; vb[6] = 16'h8000; vc[6] = 1'b0;
    va[7] = 16'h3C3C; vb[7] = 16'h1111; vc[7] = 1'b1;
    for (int i = 0; i < 8; i++) exp_q[i] = ref_sub(va[i], vb[i], vc[i]);

    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 40) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = va[sent];
        bus.b        = vb[sent];
        bus.bin      = vc[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (!bus.out_ready && bus.out_valid) begin
        chk("t5.stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5.stall_hold",     32'(bus.diff),     32'(exp_q[recv][W-1:0]));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("t5.diff", 32'(bus.diff), 32'(exp_q[recv][W-1:0]));
        chk("t5.zero", 32'(bus.zero), 32'(exp_q[recv][W]));
        chk("t5.ovf",  32'(bus.ovf),  32'(exp_q[recv][W+1]));
        chk("t5.bout", 32'(bus.bout), 32'(exp_q[recv][W+2]));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5.all_received", 32'(recv), 32'd8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5.drained", 32'(bus.out_valid), 32'd0);

    // Three beats accepted, reset pulsed while the first one is at the output.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h0100 + 16'(i);
      bus.b        = 16'h0001;
      bus.bin      = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6.pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6.rst_diff",  32'(bus.diff),      32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t6.no_stale", 32'(bus.out_valid), 32'd0);
    end
    run_one(16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0, 1'b0, 1'b0, "t6.next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
